// File: rtl/inject_eject_ni.sv
// Network interface between a processing element and the router local port.
// Injection goes through a small circular FIFO; ejection is a registered tap that counts valid flits.
module inject_eject_ni #(
    parameter int CHANNEL_SIZE = 64,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIM   = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      srcValid,
    input  logic [CHANNEL_SIZE-1:0]   srcFlit,
    output logic                      srcReady,
    output logic [CHANNEL_SIZE-1:0]   inPortLocal,
    output logic                      injectReq,
    input  logic                      injectGrant,
    input  logic [CHANNEL_SIZE-1:0]   outPortLocal,
    output logic                      ejValid,
    output logic [CHANNEL_SIZE-1:0]   ejFlit,
    output logic [15:0]               ejCount,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic                      starved
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = ($clog2(STARVE_LIM + 1) > 8) ? $clog2(STARVE_LIM + 1) : 8;
    localparam logic [AW:0]             DEPTH_C    = (AW + 1)'(DEPTH);
    localparam logic [WW-1:0]           LIM_C      = WW'(STARVE_LIM);
    localparam logic [CHANNEL_SIZE-1:0] VALID_MASK = {1'b1, {(CHANNEL_SIZE - 1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_STARVED
    } state_t;

    // ------------------------------------------------------------------
    // Injection FIFO
    // ------------------------------------------------------------------
    logic [CHANNEL_SIZE-1:0] mem [DEPTH];
    logic [AW-1:0]           rd_ptr_reg;
    logic [AW-1:0]           wr_ptr_reg;
    logic [AW:0]             count_reg;
    logic [AW:0]             count_next;
    logic                    push;
    logic                    pop;

    // Ready looks only at the current count, so a same-cycle pop never opens a full FIFO.
    assign srcReady  = (count_reg < DEPTH_C);
    assign injectReq = (count_reg != '0);
    assign occupancy = count_reg;

    always_comb begin
        push       = srcValid && srcReady;
        pop        = injectReq && injectGrant;
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + (AW + 1)'(1);
            2'b01:   count_next = count_reg - (AW + 1)'(1);
            default: count_next = count_reg;
        endcase
    end

    // Head is shown with the valid bit forced; an empty FIFO presents an idle (all-zero) channel.
    assign inPortLocal = injectReq ? (mem[rd_ptr_reg] | VALID_MASK) : '0;

    // Storage is never reset: the count alone decides what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= srcFlit;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
        end
    end

    // ------------------------------------------------------------------
    // Starvation monitor
    // ------------------------------------------------------------------
    state_t          state_reg;
    logic [WW-1:0]   wait_cnt_reg;
    logic [WW-1:0]   wait_cnt_inc;
    logic            starved_reg;

    assign wait_cnt_inc = wait_cnt_reg + WW'(1);
    assign starved      = starved_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
            starved_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    wait_cnt_reg <= '0;
                    starved_reg  <= 1'b0;
                    if (count_next != '0) begin
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (count_next == '0) begin
                        state_reg    <= ST_IDLE;
                        wait_cnt_reg <= '0;
                    end else if (pop) begin
                        wait_cnt_reg <= '0;
                    end else if (injectReq) begin
                        wait_cnt_reg <= wait_cnt_inc;
                        // Flag on the same edge the counter reaches the limit.
                        if (wait_cnt_inc == LIM_C) begin
                            state_reg   <= ST_STARVED;
                            starved_reg <= 1'b1;
                        end
                    end
                end
                ST_STARVED: begin
                    if (count_next == '0) begin
                        state_reg    <= ST_IDLE;
                        wait_cnt_reg <= '0;
                        starved_reg  <= 1'b0;
                    end else if (pop) begin
                        state_reg    <= ST_WAIT;
                        wait_cnt_reg <= '0;
                        starved_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    wait_cnt_reg <= '0;
                    starved_reg  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Ejection path
    // ------------------------------------------------------------------
    logic                    ej_valid_reg;
    logic [CHANNEL_SIZE-1:0] ej_flit_reg;
    logic [15:0]             ej_count_reg;

    assign ejValid = ej_valid_reg;
    assign ejFlit  = ej_flit_reg;
    assign ejCount = ej_count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ej_valid_reg <= 1'b0;
            ej_flit_reg  <= '0;
            ej_count_reg <= '0;
        end else begin
            ej_valid_reg <= outPortLocal[CHANNEL_SIZE-1];
            ej_flit_reg  <= outPortLocal;
            // Saturate rather than wrap so a long run never reads as few flits.
            if (outPortLocal[CHANNEL_SIZE-1] && (ej_count_reg != 16'hFFFF)) begin
                ej_count_reg <= ej_count_reg + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_inject_eject_ni.sv
// Directed bench for inject_eject_ni: fill, drain, full-with-pop, starvation,
// mid-operation reset, ejection and ejection-counter saturation.
module tb_inject_eject_ni;

    localparam logic [63:0] M = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        srcValid;
    logic [63:0] srcFlit;
    logic        srcReady;
    logic [63:0] inPortLocal;
    logic        injectReq;
    logic        injectGrant;
    logic [63:0] outPortLocal;
    logic        ejValid;
    logic [63:0] ejFlit;
    logic [15:0] ejCount;
    logic [2:0]  occupancy;
    logic        starved;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] f [10];

    inject_eject_ni #(.CHANNEL_SIZE(64), .DEPTH(4), .STARVE_LIM(15)) dut (
        .clk(clk), .reset(reset),
        .srcValid(srcValid), .srcFlit(srcFlit), .srcReady(srcReady),
        .inPortLocal(inPortLocal), .injectReq(injectReq), .injectGrant(injectGrant),
        .outPortLocal(outPortLocal), .ejValid(ejValid), .ejFlit(ejFlit),
        .ejCount(ejCount), .occupancy(occupancy), .starved(starved)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 10; i++) f[i] = 64'h0123_4567_0000_0000 + 64'(i * 17);
        reset = 1'b1; srcValid = 1'b0; srcFlit = '0; injectGrant = 1'b0; outPortLocal = '0;
        tick(); tick();
        check("rst_srcReady", 64'(srcReady), 64'd1);
        check("rst_injectReq", 64'(injectReq), 64'd0);
        check("rst_inPort", inPortLocal, 64'd0);
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_starved", 64'(starved), 64'd0);
        check("rst_ejValid", 64'(ejValid), 64'd0);
        check("rst_ejFlit", ejFlit, 64'd0);
        check("rst_ejCount", 64'(ejCount), 64'd0);
        reset = 1'b0;
        tick();

        // Fill: four pushes with no grant, fifth rejected
        srcValid = 1'b1;
        srcFlit = f[0]; tick();
        check("fill1_occ", 64'(occupancy), 64'd1);
        check("fill1_req", 64'(injectReq), 64'd1);
        check("fill1_head", inPortLocal, f[0] | M);
        srcFlit = f[1]; tick();
        srcFlit = f[2]; tick();
        srcFlit = f[3]; tick();
        check("fill4_occ", 64'(occupancy), 64'd4);
        check("fill4_ready", 64'(srcReady), 64'd0);
        srcFlit = f[4]; tick();
        check("fill5_occ", 64'(occupancy), 64'd4);
        check("fill5_head", inPortLocal, f[0] | M);
        srcValid = 1'b0;

        // Drain in order
        injectGrant = 1'b1;
        tick(); check("drain1_head", inPortLocal, f[1] | M); check("drain1_occ", 64'(occupancy), 64'd3);
        tick(); check("drain2_head", inPortLocal, f[2] | M);
        tick(); check("drain3_head", inPortLocal, f[3] | M);
        tick(); check("drain4_req", 64'(injectReq), 64'd0); check("drain4_inPort", inPortLocal, 64'd0);
        check("drain4_occ", 64'(occupancy), 64'd0);
        tick(); check("ign_grant_occ", 64'(occupancy), 64'd0);
        injectGrant = 1'b0;
        check("drain_starved", 64'(starved), 64'd0);

        // Full plus simultaneous push and pop: push rejected, one pop
        srcValid = 1'b1;
        for (int i = 4; i < 8; i++) begin srcFlit = f[i]; tick(); end
        check("full2_occ", 64'(occupancy), 64'd4);
        srcFlit = f[8]; injectGrant = 1'b1; tick();
        srcValid = 1'b0; injectGrant = 1'b0;
        check("fullpop_occ", 64'(occupancy), 64'd3);
        check("fullpop_ready", 64'(srcReady), 64'd1);
        check("fullpop_head", inPortLocal, f[5] | M);
        injectGrant = 1'b1;
        tick(); check("fp_drain1", inPortLocal, f[6] | M);
        tick(); check("fp_drain2", inPortLocal, f[7] | M);
        tick(); check("fp_drain3_occ", 64'(occupancy), 64'd0);
        injectGrant = 1'b0;

        // Starvation with one queued flit
        srcValid = 1'b1; srcFlit = f[9]; tick(); srcValid = 1'b0;
        check("starve_q_occ", 64'(occupancy), 64'd1);
        check("starve_q0", 64'(starved), 64'd0);
        for (int i = 0; i < 14; i++) tick();
        check("starve_14", 64'(starved), 64'd0);
        tick();
        check("starve_15", 64'(starved), 64'd1);
        tick();
        check("starve_hold", 64'(starved), 64'd1);
        injectGrant = 1'b1; tick(); injectGrant = 1'b0;
        check("starve_grant", 64'(starved), 64'd0);
        check("starve_grant_req", 64'(injectReq), 64'd0);
        tick();
        check("starve_idle", 64'(starved), 64'd0);

        // Mid-operation reset with two queued flits and starvation flagged
        srcValid = 1'b1;
        srcFlit = f[1]; tick();
        srcFlit = f[2]; tick();
        srcValid = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        check("pre_rst_starved", 64'(starved), 64'd1);
        check("pre_rst_occ", 64'(occupancy), 64'd2);
        #2 reset = 1'b1;
        #1;
        check("async_rst_req", 64'(injectReq), 64'd0);
        check("async_rst_occ", 64'(occupancy), 64'd0);
        check("async_rst_starved", 64'(starved), 64'd0);
        check("async_rst_ready", 64'(srcReady), 64'd1);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_inPort", inPortLocal, 64'd0);

        // Ejection: three valid, one invalid
        outPortLocal = M | 64'h11; tick();
        check("ej1_valid", 64'(ejValid), 64'd1);
        check("ej1_flit", ejFlit, M | 64'h11);
        outPortLocal = M | 64'h22; tick();
        check("ej2_valid", 64'(ejValid), 64'd1);
        outPortLocal = M | 64'h33; tick();
        check("ej3_valid", 64'(ejValid), 64'd1);
        check("ej3_count", 64'(ejCount), 64'd3);
        outPortLocal = 64'h44; tick();
        check("ej4_valid", 64'(ejValid), 64'd0);
        check("ej4_flit", ejFlit, 64'h44);
        check("ej4_count", 64'(ejCount), 64'd3);

        // Saturation: 65532 more valid flits reach 0xFFFF, then it holds
        outPortLocal = M;
        for (int i = 0; i < 65532; i++) tick();
        check("ej_sat_reach", 64'(ejCount), 64'hFFFF);
        tick(); tick();
        check("ej_sat_hold", 64'(ejCount), 64'hFFFF);
        outPortLocal = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inject_eject_ni.md
INJECT_EJECT_NI -- requirements
Module: inject_eject_ni

Interface
- REQ-001: Parameter CHANNEL_SIZE, default 64: flit width in bits; bit CHANNEL_SIZE-1 is the flit valid bit.
- REQ-002: Parameter DEPTH, default 4: injection FIFO depth in flits; power of two, 2 or greater.
- REQ-003: Parameter STARVE_LIM, default 15: consecutive ungranted request cycles before starvation is flagged.
- REQ-004: clk  input  1  sole clock; all state updates on its rising edge.
- REQ-005: reset  input  1  asynchronous, active-high reset.
- REQ-006: srcValid  input  1  processing element offers a flit.
- REQ-007: srcFlit  input  CHANNEL_SIZE  offered flit.
- REQ-008: srcReady  output  1  FIFO can accept a flit this cycle.
- REQ-009: inPortLocal  output  CHANNEL_SIZE  head flit presented to the router local input.
- REQ-010: injectReq  output  1  injection request to the router.
- REQ-011: injectGrant  input  1  router accepts the presented flit this cycle.
- REQ-012: outPortLocal  input  CHANNEL_SIZE  ejected flit from the router.
- REQ-013: ejValid  output  1  registered ejection valid.
- REQ-014: ejFlit  output  CHANNEL_SIZE  registered ejected flit.
- REQ-015: ejCount  output  16  count of ejected valid flits.
- REQ-016: occupancy  output  log2(DEPTH)+1  current FIFO fill level.
- REQ-017: starved  output  1  injection starvation flag.

Function
- REQ-018: Circular FIFO with read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a separate count register of log2(DEPTH)+1 bits; occupancy equals the count.
- REQ-019: srcReady = (count < DEPTH), combinational from the count only; a pop in the same cycle does not raise srcReady.
- REQ-020: Push occurs when srcValid and srcReady; srcFlit is stored at the write pointer, and the write pointer and count advance.
- REQ-021: Pop occurs when injectReq and injectGrant; the read pointer advances and the count decrements.
- REQ-022: Simultaneous push and pop leaves the count unchanged and moves both pointers.
- REQ-023: injectReq = (count != 0).
- REQ-024: When count is non-zero, inPortLocal is the head entry with bit CHANNEL_SIZE-1 forced to 1; when count is 0, inPortLocal is all zeros.
- REQ-025: The head flit is held stable on inPortLocal until the pop cycle; the next entry appears in the cycle after the pop.
- REQ-026: injectGrant while injectReq is 0 is ignored, with no state change.
- REQ-027: A push into an empty FIFO is visible on inPortLocal and injectReq in the following cycle; the FIFO has no bypass.
- REQ-028: Starvation FSM has three states: IDLE, WAIT and STARVED, with a wait counter of at least 8 bits.
  - IDLE: count is 0; wait counter is 0.
  - IDLE -> WAIT when count becomes non-zero.
  - WAIT: wait counter increments each cycle injectReq=1 and injectGrant=0; on a grant it clears to 0.
  - WAIT -> STARVED when the wait counter reaches STARVE_LIM.
  - STARVED -> WAIT on injectGrant, with the counter cleared.
  - WAIT or STARVED -> IDLE when a pop empties the FIFO.
- REQ-029: starved = 1 only in state STARVED; it is a registered output.
- REQ-030: Ejection path, registered each cycle:
  - ejFlit <= outPortLocal.
  - ejValid <= outPortLocal[CHANNEL_SIZE-1].
- REQ-031: ejCount increments by 1 in each cycle that outPortLocal[CHANNEL_SIZE-1] is 1, and saturates at 0xFFFF with no wrap.
- REQ-032: The ejection path runs independently of the injection path; simultaneous inject and eject activity is legal.

Reset
- REQ-033: Assertion of reset, at any time and asynchronously, forces all outputs and state to the following values:
  - pointers, count and wait counter = 0;
  - FSM = IDLE;
  - inPortLocal = 0, injectReq = 0, srcReady = 1;
  - ejValid = 0, ejFlit = 0, ejCount = 0, starved = 0, occupancy = 0.
- REQ-034: Reset in mid-operation discards all queued flits; FIFO storage contents need not be cleared.
- REQ-035: Normal operation resumes at the first rising edge of clk after reset deasserts.

Verification
- REQ-036: Fill test: push 4 flits with injectGrant=0 -> occupancy=4, srcReady=0; a 5th push is rejected; inPortLocal holds flit #1 with bit 63 = 1.
- REQ-037: Drain test: full FIFO with injectGrant=1 for 4 cycles -> flits leave in order #1..#4, then injectReq=0 and inPortLocal=0.
- REQ-038: Full plus simultaneous events: count=4, srcValid=1 and injectGrant=1 in the same cycle -> push rejected, count=3, and srcReady=1 in the next cycle.
- REQ-039: Starvation test: 1 flit queued, grant withheld -> starved=1 after the wait counter reaches 15; one grant -> FSM goes to IDLE and starved=0.
- REQ-040: Ejection test: 3 valid flits and 1 invalid flit on outPortLocal -> ejValid pattern 1,1,1,0 with one cycle of lag, ejCount=3; when preloaded to 0xFFFF, ejCount stays at 0xFFFF.
- REQ-041: Reset mid-operation: assert reset with 2 flits queued and starved=1 -> immediately injectReq=0, occupancy=0, starved=0, srcReady=1.
